// File: rtl/armv8_pkg.sv
// Shared ARMv8 pipeline constants and the fetch FSM state encoding.
package armv8_pkg;
    localparam int          XLEN          = 64;
    localparam int          ILEN          = 32;
    localparam logic [31:0] NOP_INSTR     = 32'hD503201F;
    localparam logic [31:0] HALT_SENTINEL = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble and beats load; otherwise holds.
module if_id_reg
    import armv8_pkg::*;
#(
    parameter logic [ILEN-1:0] BUBBLE_INSTR = armv8_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [ILEN-1:0] instr_in,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr,
    output logic            valid
);
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_pc    <= '0;
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
        end else if (load) begin
            r_pc    <= pc_in;
            r_instr <= instr_in;
            r_valid <= 1'b1;
        end
    end

    assign pc    = r_pc;
    assign instr = r_instr;
    assign valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, BOOT/RUN/HALT control and halt detection.
module fetch_stage
    import armv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = armv8_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            halted
);
    localparam logic [XLEN-3:0] IMEM_LIMIT = (XLEN-2)'(IMEM_WORDS);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_target;
    logic            r_halted;
    logic            w_halt_hit;
    logic            w_load;
    logic            w_flush;

    assign imem_addr  = r_pc;
    assign w_target   = {branch_target[XLEN-1:2], 2'b00};
    // Stop on the sentinel word or once the PC walks off the end of instruction memory.
    assign w_halt_hit = (imem_instr == HALT_SENTINEL) || (r_pc[XLEN-1:2] >= IMEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_halted <= (w_state_next == ST_HALT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (branch_taken)    w_state_next = ST_RUN;
                else if (w_halt_hit) w_state_next = ST_HALT;
            end
            ST_HALT: begin
                if (branch_taken) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        w_load    = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_pc_next = w_target;
                    w_flush   = 1'b1;
                end else if (w_halt_hit) begin
                    w_flush = 1'b1;
                end else if (!stall) begin
                    w_load    = 1'b1;
                    w_pc_next = r_pc + 64'd4;
                end
            end
            ST_HALT: begin
                w_flush = 1'b1;
                if (branch_taken) w_pc_next = w_target;
            end
            default: w_flush = 1'b1;
        endcase
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .flush   (w_flush),
        .pc_in   (r_pc),
        .instr_in(imem_instr),
        .pc      (if_id_pc),
        .instr   (if_id_instr),
        .valid   (if_id_valid)
    );

    assign halted = r_halted;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage against a small instruction memory model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .RESET_PC  (64'h0),
        .IMEM_WORDS(64),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a non-sentinel word so only the range check can halt there.
    always_comb begin
        if (imem_addr < 64'd256) imem_instr = mem[imem_addr[7:2]];
        else                     imem_instr = 32'hDEADBEEF;
    end

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic stl, input logic br, input logic [63:0] tgt,
                       input logic [63:0] ea, input logic [63:0] epc, input logic [31:0] ei,
                       input logic ev, input logic eh);
        vecs.push_back('{rst, stl, br, tgt, ea, epc, ei, ev, eh});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h9100_0000 | 32'(i);
        mem[0] = 32'h8b1f03e5;
        mem[1] = 32'hf84000a4;
        mem[2] = 32'h8b040086;
        mem[3] = 32'hf80010a6;
        mem[4] = 32'h0000_0000;

        //   rst stl br  target   addr     IF/ID pc  IF/ID instr   v  halted
        add(0, 0, 0, 64'h0,   64'h0,   64'h0,   NOP,          0, 0); // BOOT
        add(0, 0, 0, 64'h0,   64'h0,   64'h0,   32'h8b1f03e5, 1, 0);
        add(0, 0, 0, 64'h0,   64'h4,   64'h4,   32'hf84000a4, 1, 0);
        add(0, 1, 0, 64'h0,   64'h8,   64'h4,   32'hf84000a4, 1, 0); // stall x3
        add(0, 1, 0, 64'h0,   64'h8,   64'h4,   32'hf84000a4, 1, 0);
        add(0, 1, 0, 64'h0,   64'h8,   64'h4,   32'hf84000a4, 1, 0);
        add(0, 0, 0, 64'h0,   64'h8,   64'h8,   32'h8b040086, 1, 0);
        add(0, 1, 1, 64'h21,  64'hC,   64'h0,   NOP,          0, 0); // branch beats stall
        add(0, 0, 0, 64'h0,   64'h20,  64'h20,  32'h91000008, 1, 0);
        add(0, 0, 1, 64'hC,   64'h24,  64'h0,   NOP,          0, 0);
        add(0, 0, 0, 64'h0,   64'hC,   64'hC,   32'hf80010a6, 1, 0);
        add(0, 0, 0, 64'h0,   64'h10,  64'h0,   NOP,          0, 1); // sentinel
        add(0, 1, 0, 64'h0,   64'h10,  64'h0,   NOP,          0, 1); // stall in HALT
        add(0, 0, 1, 64'h4,   64'h10,  64'h0,   NOP,          0, 0); // leave HALT
        add(0, 0, 0, 64'h0,   64'h4,   64'h4,   32'hf84000a4, 1, 0);
        add(0, 0, 1, 64'hFC,  64'h8,   64'h0,   NOP,          0, 0);
        add(0, 0, 0, 64'h0,   64'hFC,  64'hFC,  32'h9100003F, 1, 0); // last word
        add(0, 0, 0, 64'h0,   64'h100, 64'h0,   NOP,          0, 1); // range halt
        add(0, 0, 1, 64'h0,   64'h100, 64'h0,   NOP,          0, 0);
        add(0, 0, 0, 64'h0,   64'h0,   64'h0,   32'h8b1f03e5, 1, 0);
        add(0, 0, 0, 64'h0,   64'h4,   64'h4,   32'hf84000a4, 1, 0);
        add(1, 0, 1, 64'h40,  64'h8,   64'h0,   NOP,          0, 0); // reset beats branch
        add(0, 0, 0, 64'h0,   64'h0,   64'h0,   NOP,          0, 0); // BOOT again
        add(0, 0, 0, 64'h0,   64'h0,   64'h0,   32'h8b1f03e5, 1, 0);

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_addr",   -1, imem_addr, 64'h0);
        check("reset_pc",     -1, if_id_pc, 64'h0);
        check("reset_instr",  -1, 64'(if_id_instr), 64'(NOP));
        check("reset_valid",  -1, 64'(if_id_valid), 64'h0);
        check("reset_halted", -1, 64'(halted), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            check("imem_addr", i, imem_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check("if_id_pc",    i, if_id_pc, vecs[i].exp_pc);
            check("if_id_instr", i, 64'(if_id_instr), 64'(vecs[i].exp_instr));
            check("if_id_valid", i, 64'(if_id_valid), 64'(vecs[i].exp_valid));
            check("halted",      i, 64'(halted), 64'(vecs[i].exp_halted));
            $display("vec %0d: rst=%0b stall=%0b br=%0b tgt=%h -> pc=%h instr=%h v=%0b halted=%0b",
                     i, vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt,
                     if_id_pc, if_id_instr, if_id_valid, halted);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
